// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative radix-2 M-extension unit (MUL/MULH*/DIV*/REM*), one op
//            in flight, stalls EX via hold_pipeline. Optional multiply early-out
//            is enabled by defining MULDIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  valid,
  output logic                  busy,
  output logic                  hold_pipeline
);

  localparam int                   c_W        = DATA_WIDTH;
  localparam logic [2:0]           c_OP_MULH  = 3'b001;
  localparam logic [2:0]           c_OP_MULSU = 3'b010;
  localparam logic [2:0]           c_OP_DIV   = 3'b100;
  localparam logic [2:0]           c_OP_REM   = 3'b110;
  localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(c_W - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [c_W-1:0]       c_MIN      = {1'b1, {(c_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_op;
  logic                   r_neg;
  logic [c_W-1:0]         r_b;
  logic [2*c_W-1:0]       r_acc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [c_W-1:0]         r_result;
  logic                   r_valid;
  logic                   r_busy;

  // Operand decode and magnitudes (unsigned view of -2^(W-1) is exact)
  logic                   w_a_signed;
  logic                   w_b_signed;
  logic                   w_a_neg;
  logic                   w_b_neg;
  logic [c_W-1:0]         w_a_mag;
  logic [c_W-1:0]         w_b_mag;
  logic                   w_b_zero;
  logic                   w_ovf;
  logic                   w_fast;
  logic [c_W-1:0]         w_fast_res;

  assign w_a_signed = (op == c_OP_MULH) || (op == c_OP_MULSU) ||
                      (op == c_OP_DIV)  || (op == c_OP_REM);
  assign w_b_signed = (op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM);
  assign w_a_neg    = w_a_signed && operand_A[c_W-1];
  assign w_b_neg    = w_b_signed && operand_B[c_W-1];
  assign w_a_mag    = w_a_neg ? -operand_A : operand_A;
  assign w_b_mag    = w_b_neg ? -operand_B : operand_B;
  assign w_b_zero   = (operand_B == '0);
  assign w_ovf      = !op[0] && (operand_A == c_MIN) && (operand_B == '1);
  assign w_fast     = op[2] && (w_b_zero || w_ovf);
  assign w_fast_res = w_b_zero ? (op[1] ? operand_A : '1)
                               : (op[1] ? '0 : operand_A);

  // Multiply step: conditional add into the upper half, carry kept, shift right
  logic [c_W:0]           w_mul_sum;
  logic [c_W:0]           w_mul_hi;
  logic [2*c_W-1:0]       w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*c_W-1:c_W]} + {1'b0, r_b};
  assign w_mul_hi   = r_acc[0] ? w_mul_sum : {1'b0, r_acc[2*c_W-1:c_W]};
  assign w_mul_next = {w_mul_hi, r_acc[c_W-1:1]};

  // Restoring divide step on remainder:quotient
  logic [c_W:0]           w_rem_sh;
  logic                   w_ge;
  logic [c_W-1:0]         w_rem_diff;
  logic [2*c_W-1:0]       w_div_next;

  assign w_rem_sh   = r_acc[2*c_W-1:c_W-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_diff = w_rem_sh[c_W-1:0] - r_b;
  assign w_div_next = {(w_ge ? w_rem_diff : w_rem_sh[c_W-1:0]), r_acc[c_W-2:0], w_ge};

  // Sign fix-up and result selection
  logic [2*c_W-1:0]       w_prod;
  logic [c_W-1:0]         w_quot;
  logic [c_W-1:0]         w_rem;
  logic [c_W-1:0]         w_fix_res;

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quot = r_neg ? -r_acc[c_W-1:0] : r_acc[c_W-1:0];
  assign w_rem  = r_neg ? -r_acc[2*c_W-1:c_W] : r_acc[2*c_W-1:c_W];

  always_comb begin
    w_fix_res = w_rem;
    case (r_op)
      3'b000:                 w_fix_res = w_prod[c_W-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*c_W-1:c_W];
      3'b100, 3'b101:         w_fix_res = w_quot;
      default:                w_fix_res = w_rem;
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Remaining multiplier bits; once empty the accumulator only needs realigning
  logic [c_W-1:0]         r_mplr;
  logic                   w_mul_early;
  logic [CNT_WIDTH-1:0]   w_shamt;

  assign w_mul_early = (r_mplr[c_W-1:1] == '0);
  assign w_shamt     = CNT_WIDTH'(c_W) - (r_cnt + c_CNT_ONE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      r_mplr   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_op  <= op;
              r_cnt <= '0;
              r_neg <= (op[2] && op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
              if (op[2]) begin
                r_b   <= w_b_mag;
                r_acc <= {{c_W{1'b0}}, w_a_mag};
              end else begin
                r_b   <= w_a_mag;
                r_acc <= {{c_W{1'b0}}, w_b_mag};
              end
`ifdef MULDIV_EARLY_OUT_EN
              r_mplr <= w_b_mag;
`endif
              if (w_fast) begin
                r_result <= w_fast_res;
                r_valid  <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                r_busy  <= 1'b1;
                r_state <= S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
                if (!op[2] && (w_b_mag == '0)) begin
                  r_state <= S_FIX;
                end
`endif
              end
            end
          end
          S_RUN: begin
            r_cnt <= r_cnt + c_CNT_ONE;
            if (!r_op[2]) begin
              r_acc <= w_mul_next;
`ifdef MULDIV_EARLY_OUT_EN
              r_mplr <= r_mplr >> 1;
              if (w_mul_early) begin
                r_acc   <= w_mul_next >> w_shamt;
                r_state <= S_FIX;
              end
`endif
            end else begin
              r_acc <= w_div_next;
            end
            if (r_cnt == c_CNT_LAST) begin
              r_state <= S_FIX;
            end
          end
          S_FIX: begin
            r_result <= w_fix_res;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign result        = r_result;
  assign valid         = r_valid;
  assign busy          = r_busy;
  assign hold_pipeline = ((r_state == S_IDLE) && start && !flush) || r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Scoreboard bench for mul_div_unit: directed corner cases plus
//            randomized ops against a 64-bit arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  operand_A;
  logic [W-1:0]  operand_B;
  logic          flush;
  logic [W-1:0]  result;
  logic          valid;
  logic          busy;
  logic          hold_pipeline;

  always #5 clk = ~clk;

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .operand_A     (operand_A),
    .operand_B     (operand_B),
    .flush         (flush),
    .result        (result),
    .valid         (valid),
    .busy          (busy),
    .hold_pipeline (hold_pipeline)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;
  int           total = 0;
  int           bad   = 0;
  logic         prev_valid = 1'b0;

  // RISC-V M-extension semantics from plain 64-bit arithmetic
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] m;
    int           hi;
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    m  = b;
    hi = -1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[2]) begin
      if (o == 3'd1 && b[W-1]) m = -b;
      for (int i = 0; i < W; i++) if (m[i]) hi = i;
      return (hi < 0) ? 2 : hi + 3;
    end
`endif
    return W + 2 + hi - hi + (m == m ? 0 : 0);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse pops one expectation
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got result %h with nothing expected", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          bad++;
          $display("FAIL result: got %h expected %h", result, e);
        end
      end
      if (prev_valid === 1'b1) begin
        total++;
        bad++;
        $display("FAIL valid_pulse_width: got 2+ cycles expected 1");
      end
    end
    prev_valid = valid;
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the next IDLE cycle
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    int lat;
    int exp_lat;
    bit hold_ok;
    exp_lat = lat_of(o, a, b);
    op = o; operand_A = a; operand_B = b; start = 1'b1;
    exp_q.push_back(model(o, a, b));
    last_res = model(o, a, b);
    #1;
    check({name, " hold_at_start"}, {31'b0, hold_pipeline}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); operand_A = $urandom; operand_B = $urandom;
    lat = 1;
    hold_ok = 1'b1;
    while (valid !== 1'b1 && lat < 200) begin
      if (hold_pipeline !== 1'b1) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    if (exp_lat > 1) check({name, " hold_while_running"}, {31'b0, hold_ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; operand_A = '0; operand_B = '0;
    last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 32'h0);
    check("reset valid", {31'b0, valid}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset hold", {31'b0, hold_pipeline}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(3'd0, 32'd7, 32'd6, "mul_7x6");
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    do_op(3'd5, 32'h8000_0000, 32'd3, "divu_min_3");
    do_op(3'd4, 32'h1234_5678, 32'd0, "div_by_0");
    do_op(3'd7, 32'hDEAD_BEEF, 32'd0, "remu_by_0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    do_op(3'd0, 32'd5, 32'd1, "mul_5x1");

    // start together with flush in IDLE must neither stall nor launch
    start = 1'b1; flush = 1'b1; op = 3'd0; operand_A = 32'd3; operand_B = 32'd3;
    #1;
    check("idle_flush hold", {31'b0, hold_pipeline}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush busy", {31'b0, busy}, 32'd0);

    // flush mid-RUN: no pulse, result retained, immediate restart
    start = 1'b1; op = 3'd0; operand_A = 32'd11; operand_B = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush hold", {31'b0, hold_pipeline}, 32'd0);
    check("flush result_kept", result, last_res);
    do_op(3'd3, 32'h0001_0000, 32'h0003_0000, "after_flush");

    // synchronous reset mid-RUN
    start = 1'b1; op = 3'd5; operand_A = 32'd1000; operand_B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst result", result, 32'h0);
    check("midrun_rst busy", {31'b0, busy}, 32'd0);
    check("midrun_rst valid", {31'b0, valid}, 32'd0);
    last_res = '0;
    do_op(3'd5, 32'd1000, 32'd7, "after_rst");

    for (int n = 0; n < 60; n++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), "random");
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, multi-cycle M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the EX-stage ALU and shares its operand buses.
- Iterative radix-2 shift-add multiply and restoring divide; one operation in flight.
- Raises hold_pipeline while running so the pipeline stalls EX until the result is valid.

Parameters:
- DATA_WIDTH, 32, operand/result width W (any even value >= 8).
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_A  input  W  rs1 (dividend / multiplicand).
- operand_B  input  W  rs2 (divisor / multiplier).
- flush  input  1  abort current operation (branch/jump kill).
- result  output  W  registered result; holds last value until the next result is written.
- valid  output  1  one-cycle pulse: result is new.
- busy  output  1  state is RUN or FIX.
- hold_pipeline  output  1  combinational: (state==IDLE && start && !flush) || busy.

Behaviour:
- Reset: state=IDLE, result=0, valid=0, busy=0, counter=0, internal registers=0. rst overrides start and flush.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 and flush=0: latch op.
  - Signed ops (MULH, DIV, REM, and operand_A of MULHSU): latch magnitudes and record result sign.
  - Clear the 2W accumulator, counter=0, go to RUN.
  - Fast paths go directly to DONE and load result:
    - divide by zero: DIV/DIVU -> all ones; REM/REMU -> operand_A.
    - signed overflow (A = -2^(W-1), B = -1): DIV -> A; REM -> 0.
- RUN:
  - One iteration per cycle; counter increments.
  - Multiply: if multiplier LSB is 1, add multiplicand into the upper half; shift right.
  - Divide: shift remainder:quotient left; trial-subtract divisor; set quotient bit if non-negative.
  - After W iterations go to FIX.
- FIX:
  - Apply sign: two's-complement negate the product, the quotient, or the remainder (remainder takes the dividend's sign).
  - Select result: MUL = low W bits; MULH* = high W bits; DIV* = quotient; REM* = remainder.
  - Load result, go to DONE.
- DONE: valid=1 for this cycle only; go to IDLE.
- Latency: valid asserted in the cycle after edge W+2 counted from the start-sampling edge (34 edges for W=32). Fast paths: the cycle after edge 1.
- A back-to-back start is accepted in the IDLE cycle that follows DONE. start in RUN/FIX/DONE is ignored.
- flush in any state: next state IDLE; valid stays 0; result unchanged. In the same cycle, hold_pipeline drops to 0 whenever state is IDLE.
- Operands only need to be stable in the start cycle.
- All negation and addition is performed at W+1 bits so that -2^(W-1) is handled correctly.
- MULHSU treats operand_B as unsigned.
- MULHU and DIVU/REMU never negate.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply leaves RUN as soon as the remaining multiplier register is zero, going to FIX with the accumulator realigned by the remaining shift count.
  - Latency for multiply = (index of highest set bit of |multiplier|) + 3 edges; a zero multiplier gives 2 edges.
  - Results are identical to the fixed-latency version. Divide is unaffected.
- Undefined: always W iterations. Latency is fixed as stated in Behaviour.

Test Plan:
- MUL: A=7, B=6 -> result=42 with valid pulse after exactly 34 edges (W=32); hold_pipeline=1 from the start cycle until the DONE cycle.
- MULH/MULHSU/MULHU with A=0xFFFFFFFF, B=0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHSU -> 0xFFFFFFFF
  - MULHU -> 0xFFFFFFFE
- DIV and REM:
  - DIV A=-7, B=2 -> 0xFFFFFFFD (-3).
  - REM A=-7, B=2 -> 0xFFFFFFFF (-1).
  - DIVU A=0x80000000, B=3 -> 0x2AAAAAAA.
- Corner cases:
  - DIV by 0 -> 0xFFFFFFFF, valid after 1 edge.
  - REMU by 0 -> A.
  - DIV 0x80000000 / -1 -> 0x80000000.
  - REM 0x80000000 % -1 -> 0.
- flush at RUN iteration 10 -> no valid pulse; result keeps its prior value; a new start the next cycle completes correctly.
- rst asserted mid-RUN -> next cycle IDLE, result=0, busy=0. With MULDIV_EARLY_OUT_EN: MUL A=5, B=1 -> result 5 in 3 edges.
